display_share_scheduler: RTL and testbench
==========================================

// Module: display_share_scheduler
// PURPOSE
//  Round-robin scheduler sharing one NUM_SEGMENTS-digit 7-segment display among
//  NUM_REQ requesters, e.g. button-counter instances each exporting a hex value.
//  Owns the digit-scan timing, grants display ownership for a dwell period and
//  hands over only at frame boundaries, so no frame mixes two owners' digits.
//  Sits between the counter instances and the board anode/cathode pins.
// PARAMETERS
//  NUM_REQ      2     number of requesters (>=1)
//  NUM_SEGMENTS 8     digits on the display (>=2)
//  CLK_PER      10    clock period, ns
//  REFR_RATE    1000  digit-step rate, Hz; TICK_CYC = 1e9/(CLK_PER*REFR_RATE), min 1
//  DWELL_FRAMES 250   frames an owner keeps the display before contention may switch it
// PORTS
//  clk      in   1                      system clock
//  reset    in   1                      synchronous, active-high reset
//  req      in   NUM_REQ                requester i wants the display (level)
//  value    in   NUM_REQ*NUM_SEGMENTS*4 packed hex digits; requester i at [i*NS*4 +: NS*4]
//  hold     in   1                      1 = freeze current owner (no dwell switch)
//  grant    out  NUM_REQ                one-hot owner, 0 when idle
//  anode    out  NUM_SEGMENTS           active-low digit enables
//  cathode  out  8                      active-low {dp,g,f,e,d,c,b,a}; dp always 1
// BEHAVIOUR
//  - Reset: state IDLE, grant=0, anode='1, cathode=8'hFF, digit idx=0, tick cnt=0,
//    dwell cnt=0, rr pointer=0 (req[0] highest priority first). Reset overrides all.
//  - Tick: 1-cycle pulse every TICK_CYC clocks while not IDLE; digit idx increments
//    per tick, wraps NUM_SEGMENTS-1 -> 0; a wrap ends a frame.
//  - FSM IDLE: outputs blanked. Any req bit set -> next cycle SHOW; grant = first set
//    bit at/after rr pointer (wrapping); digit idx, tick cnt, dwell cnt cleared.
//  - FSM SHOW: one cycle after each tick (and on entry), anode = ~(1<<idx),
//    cathode = hex7seg(owner digit idx). Outputs registered; 1-cycle latency from tick.
//  - Dwell cnt increments per frame, saturates at DWELL_FRAMES.
//  - Decision only at the tick that wraps idx (frame end), priority order:
//    1. owner req low: release; other req pending -> grant next rr, else IDLE.
//    2. dwell done, hold=0, another req pending -> grant next rr requester.
//    3. else keep owner.
//    On any grant change: rr pointer = new owner+1 mod NUM_REQ; dwell cnt=0.
//  - Owner req drop mid-frame: keep showing until frame end, then rule 1.
//  - Owner drop and dwell expiry at same frame end: rule 1 wins.
//  - NUM_REQ=1 or no other req: owner never switched by dwell.
//  - value not latched: digit sampled at the cycle it is loaded into cathode.
//  - Hex map 0-F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
// CONFIGURATION
//  `SEG_LEADING_ZERO_BLANK_EN defined: digits above the most-significant non-zero
//  digit of the owner's value have anode held 1 (off); digit 0 always lit, so
//  value 0 shows a single "0". Scan timing unchanged (blanked slots still take a tick).
//  Undefined: all NUM_SEGMENTS digits always lit, leading zeros shown as C0.
// TESTING (bench: CLK_PER=10, REFR_RATE=25_000_000 -> TICK_CYC=4, NUM_SEGMENTS=8,
//          DWELL_FRAMES=2, NUM_REQ=2)
//  1. reset 5 cycles, req=0 for 200 cycles -> grant=0, anode=8'hFF, cathode=8'hFF.
//  2. req=01, value0=32'h0000_00A5 -> grant=01 next cycle; slots: anode=FE cath=92,
//     anode=FD cath=88, anode=FB..7F cath=C0; each held 4 cycles.
//  3. req=11, value1=32'h1234_5678 -> grant 01 for 2 frames (64 cycles), then 10,
//     switch only on idx wrap; alternates thereafter.
//  4. as 3 with hold=1 -> grant stays 01 for >=10 frames; hold=0 -> switches at next
//     frame end.
//  5. req=01 owner, drop req[0] at idx=3 -> display continues to idx=7, then IDLE,
//     outputs FF; assert reset mid-SHOW -> next cycle all reset values.
//  6. `SEG_LEADING_ZERO_BLANK_EN, value0=32'h0000_00A5 -> idx 2..7 anode=8'hFF;
//     value0=0 -> only idx 0 lit, cath=C0.

Source files
------------

// File: rtl/display_share_scheduler.sv
// Round-robin owner of a shared multiplexed 7-segment display; handover only at frame end.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN turns off digits above the owner's top non-zero digit.
//   state | meaning
//   IDLE  | no owner, display blanked
//   SHOW  | owner granted, scanning one digit per tick
module display_share_scheduler #(
   parameter int NUM_REQ      = 2,
   parameter int NUM_SEGMENTS = 8,
   parameter int CLK_PER      = 10,
   parameter int REFR_RATE    = 1000,
   parameter int DWELL_FRAMES = 250
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ*NUM_SEGMENTS*4-1:0]   value,
   input  logic                                hold,
   output logic [NUM_REQ-1:0]                  grant,
   output logic [NUM_SEGMENTS-1:0]             anode,
   output logic [7:0]                          cathode
);
   localparam int     NS       = NUM_SEGMENTS;
   localparam longint TICK_RAW = 64'd1_000_000_000 / (longint'(CLK_PER) * longint'(REFR_RATE));
   localparam int     TICK_CYC = (TICK_RAW < 1) ? 1 : int'(TICK_RAW);
   localparam int     TW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam int     IW       = $clog2(NS);
   localparam int     OW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int     DW       = (DWELL_FRAMES > 0) ? $clog2(DWELL_FRAMES + 1) : 1;

   typedef enum logic {ST_IDLE, ST_SHOW} state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [OW-1:0]   rr_q, rr_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [DW-1:0]   dwell_q, dwell_d, dwell_inc;
   logic [NS-1:0]   anode_q, anode_d;
   logic [7:0]      cathode_q, cathode_d;
   logic            tick, load;
   logic [OW:0]     pick_idle, pick_next;
   logic [NS*4-1:0] ov;
   logic [3:0]      dig;
`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic [IW-1:0]   msd;
`endif

   function automatic logic [7:0] hex7seg(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
         4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
         4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
         4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // Returns {found, index} of the first set request in span slots starting at base (wrapping).
   function automatic logic [OW:0] rr_pick(input logic [NUM_REQ-1:0] r, input int base, input int span);
      logic [OW:0] res;
      int          c;
      res = '0;
      for (int k = 0; k < span; k++) begin
         c = (base + k) % NUM_REQ;
         if (!res[OW] && r[c]) res = {1'b1, OW'(c)};
      end
      return res;
   endfunction

   function automatic logic [OW-1:0] after(input logic [OW-1:0] o);
      return OW'((int'(o) + 1) % NUM_REQ);
   endfunction

   assign tick = (state_q == ST_SHOW) && (tick_q == TW'(TICK_CYC - 1));

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      idx_d     = idx_q;
      tick_d    = tick_q;
      dwell_d   = dwell_q;
      anode_d   = anode_q;
      cathode_d = cathode_q;
      load      = 1'b0;
      dwell_inc = (dwell_q == DW'(DWELL_FRAMES)) ? dwell_q : dwell_q + DW'(1);
      pick_idle = rr_pick(req, int'(rr_q), NUM_REQ);
      pick_next = rr_pick(req, int'(owner_q) + 1, NUM_REQ - 1);

      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               state_d = ST_SHOW;
               owner_d = pick_idle[OW-1:0];
               rr_d    = after(pick_idle[OW-1:0]);
               idx_d   = '0;
               tick_d  = '0;
               dwell_d = '0;
               load    = 1'b1;
            end
         end
         ST_SHOW: begin
            if (!tick) begin
               tick_d = tick_q + TW'(1);
            end else begin
               tick_d = '0;
               load   = 1'b1;
               if (idx_q != IW'(NS - 1)) begin
                  idx_d = idx_q + IW'(1);
               end else begin
                  idx_d = '0;
                  // Owner release takes precedence over dwell expiry at the same frame end.
                  if (!req[owner_q]) begin
                     dwell_d = '0;
                     if (pick_next[OW]) begin
                        owner_d = pick_next[OW-1:0];
                        rr_d    = after(pick_next[OW-1:0]);
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else if ((dwell_inc == DW'(DWELL_FRAMES)) && !hold && pick_next[OW]) begin
                     owner_d = pick_next[OW-1:0];
                     rr_d    = after(pick_next[OW-1:0]);
                     dwell_d = '0;
                  end else begin
                     dwell_d = dwell_inc;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ov = '0;
      for (int r = 0; r < NUM_REQ; r++)
         if (owner_d == OW'(r)) ov = value[r*NS*4 +: NS*4];
      dig = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      msd = '0;
`endif
      for (int j = 0; j < NS; j++) begin
         if (idx_d == IW'(j)) dig = ov[j*4 +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
         if (ov[j*4 +: 4] != 4'h0) msd = IW'(j);
`endif
      end

      if (state_d == ST_IDLE) begin
         anode_d   = '1;
         cathode_d = 8'hFF;
      end else if (load) begin
         cathode_d = hex7seg(dig);
`ifdef SEG_LEADING_ZERO_BLANK_EN
         anode_d   = (idx_d <= msd) ? ~({{(NS-1){1'b0}}, 1'b1} << idx_d) : '1;
`else
         anode_d   = ~({{(NS-1){1'b0}}, 1'b1} << idx_d);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         owner_q   <= '0;
         rr_q      <= '0;
         idx_q     <= '0;
         tick_q    <= '0;
         dwell_q   <= '0;
         anode_q   <= '1;
         cathode_q <= 8'hFF;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         idx_q     <= idx_d;
         tick_q    <= tick_d;
         dwell_q   <= dwell_d;
         anode_q   <= anode_d;
         cathode_q <= cathode_d;
      end
   end

   always_comb begin
      grant = '0;
      if (state_q == ST_SHOW)
         for (int r = 0; r < NUM_REQ; r++)
            if (owner_q == OW'(r)) grant[r] = 1'b1;
   end

   assign anode   = anode_q;
   assign cathode = cathode_q;

endmodule

// File: tb/tb_display_share_scheduler.sv
// Directed bench for display_share_scheduler: 2 requesters, 8 digits, 4-cycle tick, 2-frame dwell.
module tb_display_share_scheduler;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [63:0] value = 64'h0;
   logic        hold = 1'b0;
   logic [1:0]  grant;
   logic [7:0]  anode;
   logic [7:0]  cathode;

   int checks = 0;
   int errors = 0;
   int s;
   logic [7:0] exp_an;
   logic [1:0] exp_gr;
   logic [7:0] cath_a5 [8] = '{8'h92, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

   display_share_scheduler #(
      .NUM_REQ(2), .NUM_SEGMENTS(8), .CLK_PER(10), .REFR_RATE(25_000_000), .DWELL_FRAMES(2)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .value(value), .hold(hold),
      .grant(grant), .anode(anode), .cathode(cathode)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = 2'b00; hold = 1'b0; value = 64'h0;
      step(5);
      reset = 1'b0;
   endtask

   initial begin
      // idle after reset
      do_reset();
      step(200);
      check_val("idle_grant",   32'(grant),   32'h0);
      check_val("idle_anode",   32'(anode),   32'hFF);
      check_val("idle_cathode", 32'(cathode), 32'hFF);

      // single owner scan of 0x000000A5
      req = 2'b01; value[31:0] = 32'h0000_00A5;
      for (int k = 0; k < 32; k++) begin
         step(1);
         s = k / 4;
         exp_an = ~(8'h01 << s);
         check_val("scan_grant", 32'(grant), 32'h1);
         check_val("scan_anode", 32'(anode), 32'(exp_an));
         check_val("scan_cath",  32'(cathode), 32'(cath_a5[s]));
      end

      // two requesters alternate every 2 frames
      do_reset();
      req = 2'b11; value = {32'h1234_5678, 32'h0000_00A5};
      for (int k = 0; k <= 128; k++) begin
         step(1);
         exp_gr = (((k / 64) % 2) == 0) ? 2'b01 : 2'b10;
         check_val("rr_grant", 32'(grant), 32'(exp_gr));
         if (k == 64) begin
            check_val("rr_sw_anode", 32'(anode),   32'hFE);
            check_val("rr_sw_cath",  32'(cathode), 32'h80);
         end
         if (k == 68) begin
            check_val("rr_d1_anode", 32'(anode),   32'hFD);
            check_val("rr_d1_cath",  32'(cathode), 32'hF8);
         end
      end

      // hold freezes owner; release switches at the next frame end
      do_reset();
      hold = 1'b1; req = 2'b11; value = {32'h1234_5678, 32'h0000_00A5};
      for (int k = 0; k <= 352; k++) begin
         step(1);
         exp_gr = (k < 352) ? 2'b01 : 2'b10;
         check_val("hold_grant", 32'(grant), 32'(exp_gr));
         if (k == 320) hold = 1'b0;
      end

      // owner drops mid-frame: finish frame, then idle
      do_reset();
      req = 2'b01; value[31:0] = 32'h0000_00A5;
      for (int k = 0; k <= 32; k++) begin
         step(1);
         if (k < 32) begin
            exp_an = ~(8'h01 << (k / 4));
            check_val("drop_grant", 32'(grant), 32'h1);
            check_val("drop_anode", 32'(anode), 32'(exp_an));
         end else begin
            check_val("drop_idle_grant", 32'(grant),   32'h0);
            check_val("drop_idle_anode", 32'(anode),   32'hFF);
            check_val("drop_idle_cath",  32'(cathode), 32'hFF);
         end
         if (k == 12) req = 2'b00;
      end

      // reset asserted mid-SHOW
      req = 2'b01;
      step(1);
      step(5);
      check_val("pre_rst_anode", 32'(anode), 32'hFD);
      reset = 1'b1;
      step(1);
      check_val("rst_grant", 32'(grant),   32'h0);
      check_val("rst_anode", 32'(anode),   32'hFF);
      check_val("rst_cath",  32'(cathode), 32'hFF);
      step(3);
      check_val("rst_hold_grant", 32'(grant), 32'h0);
      reset = 1'b0;
      step(1);
      check_val("post_rst_grant", 32'(grant),   32'h1);
      check_val("post_rst_anode", 32'(anode),   32'hFE);
      check_val("post_rst_cath",  32'(cathode), 32'h92);

`ifdef SEG_LEADING_ZERO_BLANK_EN
      do_reset();
      req = 2'b01; value[31:0] = 32'h0000_00A5;
      for (int k = 0; k < 32; k++) begin
         step(1);
         s = k / 4;
         exp_an = (s <= 1) ? ~(8'h01 << s) : 8'hFF;
         check_val("lzb_anode", 32'(anode), 32'(exp_an));
      end
      do_reset();
      req = 2'b01; value[31:0] = 32'h0;
      for (int k = 0; k < 32; k++) begin
         step(1);
         exp_an = (k < 4) ? 8'hFE : 8'hFF;
         check_val("lzb0_anode", 32'(anode), 32'(exp_an));
         if (k < 4) check_val("lzb0_cath", 32'(cathode), 32'hC0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
